disparity_search_ctrl: RTL
==========================

Name: disparity_search_ctrl

Overview:
- Sequences the 6x6 block SSD engine across a horizontal disparity range for one left-image block.
- For each candidate disparity d, issues one SSD request at left x = block_x and right x = block_x - d.
- Collects each SSD result and tracks the running minimum.
- Reports the best disparity and its SSD to the stereo main FSM.
- Sits between the main FSM (start/done) and the SSD block (valid/ssd handshake).

Parameters:
MAX_DISP, 16, number of candidate disparities searched (d = 0..MAX_DISP-1)
X_W, 9, width of x coordinates
Y_W, 9, width of y coordinates
SSD_W, 23, width of SSD result (holds 255*255*36)
D_W, 5, width of disparity output (>= clog2(MAX_DISP)+1)
TIMEOUT, 64, max cycles to wait for one SSD result

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
start_in  input  1  one-cycle pulse; begin search for block at block_x_in/block_y_in
block_x_in  input  X_W  left block x (sampled on accepted start)
block_y_in  input  Y_W  block y (sampled on accepted start)
busy_out  output  1  high from accepted start until done_out/err_out cycle inclusive
req_valid_out  output  1  one-cycle request pulse to SSD engine
left_x_out  output  X_W  left block x for current request
right_x_out  output  X_W  right block x for current request
y_out  output  Y_W  y for current request (same for left and right)
ssd_valid_in  input  1  SSD engine result strobe
ssd_in  input  SSD_W  SSD result
done_out  output  1  one-cycle pulse; best_* valid
err_out  output  1  one-cycle pulse; search aborted on timeout
best_disp_out  output  D_W  disparity with minimum SSD
best_ssd_out  output  SSD_W  minimum SSD

Behaviour:
- Reset (rst_in=0, asynchronous): state IDLE; all outputs 0; internal d, timer and best registers 0. Reset mid-search abandons the search; no done_out or err_out follows.
- States:
  - IDLE: start_in=1 latches block_x, block_y; d<=0; best_ssd<=all-ones; best_disp<=0; goes to ISSUE. start_in while not IDLE is ignored.
  - ISSUE (1 cycle): req_valid_out=1; left_x_out=block_x, right_x_out=block_x-d, y_out=block_y, all registered and stable through WAIT; timer<=0; goes to WAIT.
  - WAIT: on ssd_valid_in=1, if ssd_in < best_ssd (strict) then best_ssd<=ssd_in, best_disp<=d. Ties keep the smaller disparity.
    - If d == last_d, go to DONE; else d<=d+1 and go to ISSUE.
    - Otherwise timer increments; when timer reaches TIMEOUT-1 with no result, go to ERR.
  - DONE (1 cycle): done_out=1; best_disp_out/best_ssd_out updated and held until the next accepted start; goes to IDLE.
  - ERR (1 cycle): err_out=1; best_* outputs unchanged from their previous search; goes to IDLE.
- last_d = min(MAX_DISP-1, block_x): right_x never goes negative; block_x=0 yields exactly one request (d=0).
- ssd_valid_in outside WAIT, or coincident with the ISSUE cycle, is ignored. Exactly one request is outstanding at a time.
- Cycle count per search with engine latency L (result L cycles after request): start at cycle 0; first req_valid_out at cycle 1; each candidate costs L+1 cycles; done_out at cycle 1+(last_d+1)*(L+1).
- busy_out is high in ISSUE/WAIT/DONE/ERR, low in IDLE.
- All arithmetic is unsigned; comparison uses the full SSD_W bits. An ssd_in of all-ones never updates best (best_disp stays 0).

Test Plan:
- Reset mid-WAIT (block_x=40, after 3 results): rst_in low for 1 cycle -> all outputs 0 immediately; no done_out; next start runs normally.
- block_x=40, MAX_DISP=16, engine L=4, ssd_in = 1000-10*d except d=7 gives 5 -> 16 req_valid_out pulses with right_x_out 40..25; done_out at cycle 81; best_disp_out=7, best_ssd_out=5.
- block_x=3, all ssd_in=100 -> exactly 4 requests (right_x 3,2,1,0); best_disp_out=0 (tie keeps smallest); best_ssd_out=100.
- start_in pulsed again during WAIT and spurious ssd_valid_in during IDLE/ISSUE -> ignored; request count and best result unchanged.
- Engine never answers d=2 (block_x=20) -> err_out pulse at TIMEOUT cycles after third request; busy_out drops next cycle; best_* hold the previous search values.
- block_x=0 -> a single request with left_x=right_x=0; done_out follows the single result; best_disp_out=0.

Source files
------------

// File: rtl/disparity_search_ctrl_if.sv
// Request/result handshake between the disparity search controller and the 6x6 SSD engine.
// One request is outstanding at a time; the engine answers with a single ssd_valid_in strobe.
interface disparity_search_ctrl_if #(
  parameter int X_W   = 9,
  parameter int Y_W   = 9,
  parameter int SSD_W = 23
) ();
  logic             req_valid_out;
  logic [X_W-1:0]   left_x_out;
  logic [X_W-1:0]   right_x_out;
  logic [Y_W-1:0]   y_out;
  logic             ssd_valid_in;
  logic [SSD_W-1:0] ssd_in;

  modport master (
    output req_valid_out, left_x_out, right_x_out, y_out,
    input  ssd_valid_in, ssd_in
  );

  modport slave (
    input  req_valid_out, left_x_out, right_x_out, y_out,
    output ssd_valid_in, ssd_in
  );
endinterface

// File: rtl/disparity_search_ctrl.sv
// Walks candidate disparities 0..last_d for one left block, issuing one SSD request per
// candidate and keeping the first minimum; reports best disparity/SSD or a timeout abort.
module disparity_search_ctrl #(
  parameter int MAX_DISP = 16,
  parameter int X_W      = 9,
  parameter int Y_W      = 9,
  parameter int SSD_W    = 23,
  parameter int D_W      = 5,
  parameter int TIMEOUT  = 64
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [X_W-1:0]   block_x_in,
  input  logic [Y_W-1:0]   block_y_in,
  output logic             busy_out,
  output logic             done_out,
  output logic             err_out,
  output logic [D_W-1:0]   best_disp_out,
  output logic [SSD_W-1:0] best_ssd_out,
  disparity_search_ctrl_if.master ssd_bus
);

  localparam int TMR_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_ERR} state_t;

  state_t           state_q, state_d;
  logic [D_W-1:0]   d_q, last_d_q, best_disp_q;
  logic [TMR_W-1:0] timer_q;
  logic [SSD_W-1:0] best_ssd_q;
  logic [X_W-1:0]   left_x_q, right_x_q;
  logic [Y_W-1:0]   y_q;

  logic             better;
  logic             timed_out;
  logic [D_W-1:0]   cand_disp;
  logic [SSD_W-1:0] cand_ssd;

  // Strict compare: a tie never displaces the earlier (smaller) disparity.
  assign better    = ssd_bus.ssd_in < best_ssd_q;
  assign cand_disp = better ? d_q : best_disp_q;
  assign cand_ssd  = better ? ssd_bus.ssd_in : best_ssd_q;
  assign timed_out = timer_q == TMR_W'(TIMEOUT - 2);

  assign ssd_bus.left_x_out  = left_x_q;
  assign ssd_bus.right_x_out = right_x_q;
  assign ssd_bus.y_out       = y_q;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d               = state_q;
    busy_out              = 1'b1;
    done_out              = 1'b0;
    err_out               = 1'b0;
    ssd_bus.req_valid_out = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy_out = 1'b0;
        if (start_in) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        ssd_bus.req_valid_out = 1'b1;
        state_d               = S_WAIT;
      end
      S_WAIT: begin
        if (ssd_bus.ssd_valid_in) state_d = (d_q == last_d_q) ? S_DONE : S_ISSUE;
        else if (timed_out)       state_d = S_ERR;
      end
      S_DONE: begin
        done_out = 1'b1;
        state_d  = S_IDLE;
      end
      S_ERR: begin
        err_out = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      d_q           <= '0;
      last_d_q      <= '0;
      timer_q       <= '0;
      best_disp_q   <= '0;
      best_ssd_q    <= '0;
      left_x_q      <= '0;
      right_x_q     <= '0;
      y_q           <= '0;
      best_disp_out <= '0;
      best_ssd_out  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_in) begin
            left_x_q    <= block_x_in;
            right_x_q   <= block_x_in;
            y_q         <= block_y_in;
            d_q         <= '0;
            best_ssd_q  <= '1;
            best_disp_q <= '0;
            // Clamp the range so right_x never goes below zero.
            last_d_q    <= (block_x_in < X_W'(MAX_DISP - 1)) ? D_W'(block_x_in)
                                                             : D_W'(MAX_DISP - 1);
          end
        end
        S_ISSUE: timer_q <= '0;
        S_WAIT: begin
          if (ssd_bus.ssd_valid_in) begin
            best_disp_q <= cand_disp;
            best_ssd_q  <= cand_ssd;
            if (d_q == last_d_q) begin
              best_disp_out <= cand_disp;
              best_ssd_out  <= cand_ssd;
            end else begin
              d_q       <= d_q + D_W'(1);
              right_x_q <= right_x_q - X_W'(1);
            end
          end else begin
            timer_q <= timer_q + TMR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
